// File: rtl/mode_sequencer.sv
// mode_sequencer
// Front-panel mode controller for the encoder/decoder. The raw mode and
// backspace buttons are synchronised and debounced. The module then cycles
// through NUM_MODES operating modes:
//   - a short mode press advances to the next mode;
//   - a long mode press returns to mode 0;
//   - a mode change is held off while the active sub-block reports busy.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-low reset
//   btn_mode     raw mode button, active-high
//   btn_back     raw backspace button, active-high
//   busy         active sub-block busy; defers a pending mode change
//   seg_in       packed segment buses, mode k at [k*SEG_W +: SEG_W]
//   mode         current mode index
//   mode_onehot  one-hot of mode (LED indicator)
//   mode_clr     one-cycle pulse coincident with every new mode value
//   back_pulse   one-cycle pulse per debounced backspace press
//   seg_sel      segment bus of the current mode (zero for invalid modes)
module mode_sequencer #(
    parameter int NUM_MODES   = 2,
    parameter int MODE_W      = 1,
    parameter int SEG_W       = 64,
    parameter int DEB_CYCLES  = 20000,
    parameter int LONG_CYCLES = 1000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       btn_mode,
    input  logic                       btn_back,
    input  logic                       busy,
    input  logic [NUM_MODES*SEG_W-1:0] seg_in,
    output logic [MODE_W-1:0]          mode,
    output logic [NUM_MODES-1:0]       mode_onehot,
    output logic                       mode_clr,
    output logic                       back_pulse,
    output logic [SEG_W-1:0]           seg_sel
);

    localparam int DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_W   = $clog2(LONG_CYCLES + 1);
    localparam int BTN_MODE = 0;
    localparam int BTN_BACK = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HELD = 2'd1,
        S_LONG = 2'd2
    } btn_state_t;

    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_ADV  = 2'd1,
        PEND_HOME = 2'd2
    } pend_t;

    // Bit BTN_MODE / BTN_BACK of each vector belongs to the respective button.
    logic [1:0]        raw;
    logic [1:0]        sync1_q, sync2_q;
    logic [1:0]        acc_q, acc_d;
    logic [DEB_W-1:0]  deb_cnt_q [2];
    logic [DEB_W-1:0]  deb_cnt_d [2];

    logic              back_prev_q;
    logic              back_pulse_q, back_pulse_d;

    btn_state_t        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              req_adv, req_home;

    pend_t             pend_q, pend_d, pend_nxt;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              mode_clr_q, mode_clr_d;

    assign raw = {btn_back, btn_mode};

    // Debounce: the accepted level only flips after DEB_CYCLES consecutive
    // cycles of the synchronised level disagreeing with it.
    always_comb begin
        acc_d     = acc_q;
        deb_cnt_d = deb_cnt_q;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != acc_q[b]) begin
                if (deb_cnt_q[b] == DEB_W'(DEB_CYCLES - 1)) begin
                    acc_d[b]     = ~acc_q[b];
                    deb_cnt_d[b] = '0;
                end else begin
                    deb_cnt_d[b] = deb_cnt_q[b] + DEB_W'(1);
                end
            end else begin
                deb_cnt_d[b] = '0;
            end
        end
    end

    // The rise is detected from registered levels, so the pulse lands
    // one cycle after the accepted level goes high.
    assign back_pulse_d = acc_q[BTN_BACK] & ~back_prev_q;

    // Mode button press classifier.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        req_adv    = 1'b0;
        req_home   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (acc_q[BTN_MODE]) begin
                    state_d    = S_HELD;
                    hold_cnt_d = '0;
                end
            end
            S_HELD: begin
                if (!acc_q[BTN_MODE]) begin
                    req_adv = 1'b1;
                    state_d = S_IDLE;
                end else if (hold_cnt_q == HOLD_W'(LONG_CYCLES - 1)) begin
                    req_home = 1'b1;
                    state_d  = S_LONG;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            S_LONG: begin
                // The release of a long press is swallowed.
                if (!acc_q[BTN_MODE]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pending request and mode update. HOME beats ADV. A second ADV is
    // dropped while one is already waiting, so a busy window yields at most
    // one step. A request raised in a not-busy cycle is applied at once.
    always_comb begin
        pend_nxt = pend_q;
        if (req_home) begin
            pend_nxt = PEND_HOME;
        end else if (req_adv && pend_q == PEND_NONE) begin
            pend_nxt = PEND_ADV;
        end

        pend_d     = pend_nxt;
        mode_d     = mode_q;
        mode_clr_d = 1'b0;
        if (!busy) begin
            pend_d = PEND_NONE;
            case (pend_nxt)
                PEND_ADV: begin
                    // >= also pulls an out-of-range mode back to 0.
                    mode_d     = (mode_q >= MODE_W'(NUM_MODES - 1)) ? '0
                                                                    : mode_q + MODE_W'(1);
                    mode_clr_d = 1'b1;
                end
                PEND_HOME: begin
                    if (mode_q != '0) begin
                        mode_d     = '0;
                        mode_clr_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            acc_q        <= '0;
            for (int b = 0; b < 2; b++) begin
                deb_cnt_q[b] <= '0;
            end
            back_prev_q  <= 1'b0;
            back_pulse_q <= 1'b0;
            state_q      <= S_IDLE;
            hold_cnt_q   <= '0;
            pend_q       <= PEND_NONE;
            mode_q       <= '0;
            mode_clr_q   <= 1'b0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            acc_q        <= acc_d;
            deb_cnt_q    <= deb_cnt_d;
            back_prev_q  <= acc_q[BTN_BACK];
            back_pulse_q <= back_pulse_d;
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            pend_q       <= pend_d;
            mode_q       <= mode_d;
            mode_clr_q   <= mode_clr_d;
        end
    end

    // Decoded views of the registered mode; invalid modes decode to zero.
    always_comb begin
        mode_onehot = '0;
        seg_sel     = '0;
        for (int k = 0; k < NUM_MODES; k++) begin
            if (mode_q == MODE_W'(k)) begin
                mode_onehot[k] = 1'b1;
                seg_sel        = seg_in[k*SEG_W +: SEG_W];
            end
        end
    end

    assign mode       = mode_q;
    assign mode_clr   = mode_clr_q;
    assign back_pulse = back_pulse_q;

endmodule

// File: tb/tb_mode_sequencer.sv
module tb_mode_sequencer;

    localparam int NUM_MODES   = 3;
    localparam int MODE_W      = 2;
    localparam int SEG_W       = 8;
    localparam int DEB_CYCLES  = 4;
    localparam int LONG_CYCLES = 16;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       btn_mode;
    logic                       btn_back;
    logic                       busy;
    logic [NUM_MODES*SEG_W-1:0] seg_in;
    logic [MODE_W-1:0]          mode;
    logic [NUM_MODES-1:0]       mode_onehot;
    logic                       mode_clr;
    logic                       back_pulse;
    logic [SEG_W-1:0]           seg_sel;

    mode_sequencer #(
        .NUM_MODES  (NUM_MODES),
        .MODE_W     (MODE_W),
        .SEG_W      (SEG_W),
        .DEB_CYCLES (DEB_CYCLES),
        .LONG_CYCLES(LONG_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode   (btn_mode),
        .btn_back   (btn_back),
        .busy       (busy),
        .seg_in     (seg_in),
        .mode       (mode),
        .mode_onehot(mode_onehot),
        .mode_clr   (mode_clr),
        .back_pulse (back_pulse),
        .seg_sel    (seg_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          hold;
        logic [1:0]  exp_mode;
        logic [7:0]  exp_seg;
    } vec_t;

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  seg;
    } exp_t;

    vec_t vecs[3];
    exp_t sb[$];
    exp_t mon_e;

    int checks   = 0;
    int errors   = 0;
    int clr_cnt  = 0;
    int back_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press the mode button for 'hold' cycles, then let the release settle.
    task automatic press(input int hold);
        btn_mode = 1'b1;
        idle(hold);
        btn_mode = 1'b0;
        idle(20);
    endtask

    task automatic push_exp(input logic [1:0] m);
        exp_t e;
        e.mode = m;
        e.seg  = (m == 2'd0) ? 8'h11 : (m == 2'd1) ? 8'h22 : 8'h33;
        sb.push_back(e);
    endtask

    // Scoreboard: every mode_clr must match the next expected mode change.
    always @(negedge clk) begin
        if (back_pulse) back_cnt++;
        if (mode_clr) begin
            clr_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_clr actual_mode=%0d required=no mode change", mode);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_mode", 64'(mode), 64'(mon_e.mode));
                chk("sb_onehot", 64'(mode_onehot), 64'(1) << mon_e.mode);
                chk("sb_seg", 64'(seg_sel), 64'(mon_e.seg));
            end
        end
    end

    initial begin
        int c0;
        int b0;
        rst      = 1'b0;
        btn_mode = 1'b0;
        btn_back = 1'b0;
        busy     = 1'b0;
        seg_in   = {8'h33, 8'h22, 8'h11};

        vecs[0] = '{8, 2'd1, 8'h22};
        vecs[1] = '{8, 2'd2, 8'h33};
        vecs[2] = '{8, 2'd0, 8'h11};

        idle(3);
        chk("rst_mode", 64'(mode), 64'd0);
        chk("rst_onehot", 64'(mode_onehot), 64'b001);
        chk("rst_seg", 64'(seg_sel), 64'h11);
        chk("rst_clr", 64'(mode_clr), 64'd0);
        chk("rst_back", 64'(back_pulse), 64'd0);
        rst = 1'b1;
        idle(10);
        chk("idle_mode", 64'(mode), 64'd0);
        chk("idle_clr_cnt", 64'(clr_cnt), 64'd0);

        // Short presses from the vector table.
        for (int i = 0; i < 3; i++) begin
            c0 = clr_cnt;
            push_exp(vecs[i].exp_mode);
            press(vecs[i].hold);
            chk("short_mode", 64'(mode), 64'(vecs[i].exp_mode));
            chk("short_seg", 64'(seg_sel), 64'(vecs[i].exp_seg));
            chk("short_onehot", 64'(mode_onehot), 64'(1) << vecs[i].exp_mode);
            chk("short_clr_cnt", 64'(clr_cnt - c0), 64'd1);
        end

        // Bounce: never stable long enough to be accepted.
        c0 = clr_cnt;
        for (int i = 0; i < 10; i++) begin
            btn_mode = ~btn_mode;
            idle(2);
        end
        btn_mode = 1'b0;
        idle(20);
        chk("bounce_mode", 64'(mode), 64'd0);
        chk("bounce_clr_cnt", 64'(clr_cnt - c0), 64'd0);

        // Long press from mode 2.
        push_exp(2'd1);
        press(8);
        push_exp(2'd2);
        press(8);
        chk("pre_long_mode", 64'(mode), 64'd2);
        c0 = clr_cnt;
        push_exp(2'd0);
        press(30);
        chk("long_mode", 64'(mode), 64'd0);
        chk("long_clr_cnt", 64'(clr_cnt - c0), 64'd1);

        // Busy defers and collapses two presses into one step.
        c0   = clr_cnt;
        busy = 1'b1;
        press(8);
        press(8);
        chk("busy_mode", 64'(mode), 64'd0);
        chk("busy_clr_cnt", 64'(clr_cnt - c0), 64'd0);
        push_exp(2'd1);
        busy = 1'b0;
        @(negedge clk);
        chk("unbusy_clr", 64'(mode_clr), 64'd1);
        chk("unbusy_mode", 64'(mode), 64'd1);
        idle(5);
        chk("unbusy_clr_cnt", 64'(clr_cnt - c0), 64'd1);

        // Backspace press in mode 1.
        b0       = back_cnt;
        btn_back = 1'b1;
        idle(10);
        btn_back = 1'b0;
        idle(20);
        chk("back_cnt", 64'(back_cnt - b0), 64'd1);
        chk("back_mode", 64'(mode), 64'd1);

        // Asynchronous reset in the middle of a press on both buttons.
        b0       = back_cnt;
        btn_mode = 1'b1;
        btn_back = 1'b1;
        idle(5);
        #2 rst = 1'b0;
        #1;
        chk("arst_mode", 64'(mode), 64'd0);
        chk("arst_onehot", 64'(mode_onehot), 64'b001);
        chk("arst_seg", 64'(seg_sel), 64'h11);
        chk("arst_clr", 64'(mode_clr), 64'd0);
        chk("arst_back", 64'(back_pulse), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        push_exp(2'd1);
        idle(8);
        btn_mode = 1'b0;
        btn_back = 1'b0;
        idle(20);
        chk("fresh_mode", 64'(mode), 64'd1);
        chk("fresh_back_cnt", 64'(back_cnt - b0), 64'd1);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
- Parametrised top-level mode controller for the encoder/decoder front panel.
- Debounces the raw mode and backspace buttons internally and cycles through NUM_MODES operating modes.
- Short press advances the mode; long press returns to mode 0. A mode change is deferred while the active sub-block reports busy.
- Emits a one-cycle clear pulse to sub-blocks and selects that mode's 7-segment bus for the display driver.

Parameters:
NUM_MODES, 2, number of operating modes (≥2)
MODE_W, 1, width of mode index; must satisfy 2**MODE_W ≥ NUM_MODES
SEG_W, 64, width of one mode's segment bus
DEB_CYCLES, 20000, consecutive stable clk cycles required to accept a new button level
LONG_CYCLES, 1000000, clk cycles of accepted-high mode button that count as a long press

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous assert, active-low
btn_mode  in  1  raw mode button, active-high
btn_back  in  1  raw backspace button, active-high
busy  in  1  active sub-block busy (e.g. beeper playing); defers mode change
seg_in  in  NUM_MODES*SEG_W  packed segment buses; mode k occupies bits [k*SEG_W +: SEG_W]
mode  out  MODE_W  current mode index
mode_onehot  out  NUM_MODES  one-hot of mode, LED indicator
mode_clr  out  1  one-cycle pulse on every mode change
back_pulse  out  1  one-cycle pulse per debounced backspace press
seg_sel  out  SEG_W  seg_in slice for current mode

Behaviour:
- Reset (rst=0, async): mode=0, mode_onehot=1, mode_clr=0, back_pulse=0, sync flops=0, debounced levels=0, counters=0, pending=none. seg_sel=seg_in[0 +: SEG_W].
- Synchronisation: each button passes through a 2-flop synchroniser.
- Debounce (per button): the counter increments while the synced level differs from the accepted level and clears otherwise. When the counter reaches DEB_CYCLES, the accepted level flips and the counter clears.
- back_pulse: high for exactly one cycle, the cycle after the accepted btn_back level rises. Independent of mode and busy.
- Mode button FSM:
  - States: IDLE, HELD, LONG.
  - IDLE: on accepted rise, go to HELD and clear hold_cnt.
  - HELD: hold_cnt increments each cycle.
    - Accepted fall with hold_cnt < LONG_CYCLES: raise an ADV request and go to IDLE.
    - hold_cnt reaches LONG_CYCLES: raise a HOME request and go to LONG.
  - LONG: wait for accepted fall, then go to IDLE. That release raises no request.
- Request handling:
  - Each request goes into a 2-bit pending register (none/ADV/HOME).
  - HOME overwrites ADV. A new ADV while ADV is pending is dropped, so at most one advance per busy window.
  - The pending request is applied in the first cycle with busy=0, including the cycle the request is raised. Pending then returns to none.
- Applying requests:
  - ADV: mode = (mode==NUM_MODES-1) ? 0 : mode+1.
  - HOME: mode=0.
  - HOME while mode is already 0: no change and no mode_clr.
- mode_clr: registered, high for one cycle, coincident with the first cycle the new mode value is visible.
- mode_onehot and seg_sel follow the registered mode combinationally, with no additional latency.
- Mode values ≥ NUM_MODES are unreachable. If reached (e.g. by forcing), the next ADV wraps to 0 and seg_sel outputs all zeros.
- Reset mid-press: all state is discarded. A button still held after reset release must first be accepted high, which yields a fresh press.
- Simultaneous requests: a mode request and a backspace press in the same cycle are both honoured.

Test Plan (NUM_MODES=3, DEB_CYCLES=4, LONG_CYCLES=16, SEG_W=8, seg_in={8'h33,8'h22,8'h11}):
- Reset, then idle → mode=0, mode_onehot=3'b001, seg_sel=8'h11, mode_clr=0, back_pulse=0.
- Three short presses (held 8 cycles each, busy=0) → mode steps 1,2,0. mode_clr pulses once per step. seg_sel reads 8'h22, 8'h33, 8'h11.
- Bounce: btn_mode toggles every 2 cycles for 20 cycles, then goes low → no accepted edge, mode unchanged, no mode_clr.
- Long press from mode 2 (held 30 cycles) → mode=0 about 16 cycles after the accepted rise, with one mode_clr. Release causes no further change.
- busy=1 with two short presses → mode stays at its old value. Drop busy → mode advances by exactly 1, with mode_clr in the first cycle after busy falls.
- btn_back held 10 cycles while in mode 1 → exactly one back_pulse, mode unchanged. Assert rst mid-press → outputs return to reset values immediately (asynchronously).
